// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard information in, stall/forward controls out.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       Tuse_rs;
  logic [1:0]       Tuse_rt;
  logic [1:0]       TnewD;
  logic [4:0]       A_rsD;
  logic [4:0]       A_rtD;
  logic [4:0]       AwriteD;
  logic             RegWriteD;
  logic             stall;
  logic             flushE;
  logic [1:0]       fwdAD;
  logic [1:0]       fwdBD;
  logic [1:0]       fwdAE;
  logic [1:0]       fwdBE;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD, RegWriteD,
    input  stall, flushE, fwdAD, fwdBD, fwdAE, fwdBE, stall_cnt
  );

  modport slave (
    input  Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD, RegWriteD,
    output stall, flushE, fwdAD, fwdBD, fwdAE, fwdBE, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the 5-stage pipeline, tracking shadow
// E/M/W records built from Decode's Tuse/Tnew and register addresses.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  hazard_ctrl_if.slave io_bus
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       wr;
  } rec_t;

  rec_t             r_e, r_m, r_w;
  rec_t             w_d;
  logic             w_stall;
  logic [1:0]       w_fwd_ad, w_fwd_bd, w_fwd_ae, w_fwd_be;
  logic [CNT_W-1:0] r_cnt;
  logic             w_unused;

  function automatic logic dep(input logic [4:0] a, input logic [1:0] tuse,
                               input rec_t e, input rec_t m);
    logic hit_e, hit_m;
    hit_e = (a == e.dst) && e.wr && (e.dst != 5'd0) && (tuse < e.tnew);
    hit_m = (a == m.dst) && m.wr && (m.dst != 5'd0) && (tuse < m.tnew);
    return (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  // M wins over W, but only once its result has actually been produced.
  function automatic logic [1:0] fwd_sel(input logic [4:0] a,
                                         input rec_t m, input rec_t w);
    if ((a == m.dst) && m.wr && (m.dst != 5'd0) && (m.tnew == 2'd0))
      return 2'b01;
    else if ((a == w.dst) && w.wr && (w.dst != 5'd0))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    w_d      = '0;
    w_d.rs   = io_bus.A_rsD;
    w_d.rt   = io_bus.A_rtD;
    w_d.dst  = io_bus.RegWriteD ? io_bus.AwriteD : 5'd0;
    w_d.tnew = io_bus.TnewD;
    w_d.wr   = io_bus.RegWriteD;
  end

  always_comb begin
    w_stall  = dep(io_bus.A_rsD, io_bus.Tuse_rs, r_e, r_m) |
               dep(io_bus.A_rtD, io_bus.Tuse_rt, r_e, r_m);
    w_fwd_ad = fwd_sel(io_bus.A_rsD, r_m, r_w);
    w_fwd_bd = fwd_sel(io_bus.A_rtD, r_m, r_w);
    w_fwd_ae = fwd_sel(r_e.rs, r_m, r_w);
    w_fwd_be = fwd_sel(r_e.rt, r_m, r_w);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e   <= '0;
      r_m   <= '0;
      r_w   <= '0;
      r_cnt <= '0;
    end else begin
      r_e      <= w_stall ? '0 : w_d;
      r_m      <= r_e;
      r_m.tnew <= (r_e.tnew == 2'd0) ? 2'd0 : r_e.tnew - 2'd1;
      r_w      <= r_m;
      r_w.tnew <= 2'd0;
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Source addresses of M/W are kept for record completeness only.
  assign w_unused = ^{r_m.rs, r_m.rt, r_w.rs, r_w.rt, r_w.tnew};

  assign io_bus.stall     = w_stall;
  assign io_bus.flushE    = w_stall;
  assign io_bus.fwdAD     = w_fwd_ad;
  assign io_bus.fwdBD     = w_fwd_bd;
  assign io_bus.fwdAE     = w_fwd_ae;
  assign io_bus.fwdBE     = w_fwd_be;
  assign io_bus.stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued with each stimulus
// step and drained against the DUT outputs; a 2-bit counter copy checks saturation.
module tb_hazard_ctrl;

  localparam int S_STALL = 0, S_FLUSH = 1, S_FAD = 2, S_FBD = 3,
                 S_FAE = 4, S_FBE = 5, S_CNT = 6, S_CNTS = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  logic rst_s;
  int   checks;
  int   failures;
  exp_t sb[$];

  hazard_ctrl_if #(.CNT_W(32)) bus   ();
  hazard_ctrl_if #(.CNT_W(2))  bus_s ();

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk    (clk),
    .reset  (rst_s),
    .io_bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_STALL: return {31'd0, bus.stall};
      S_FLUSH: return {31'd0, bus.flushE};
      S_FAD:   return {30'd0, bus.fwdAD};
      S_FBD:   return {30'd0, bus.fwdBD};
      S_FAE:   return {30'd0, bus.fwdAE};
      S_FBE:   return {30'd0, bus.fwdBE};
      S_CNT:   return bus.stall_cnt;
      S_CNTS:  return {30'd0, bus_s.stall_cnt};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic wr);
    bus.A_rsD     = rs;
    bus.Tuse_rs   = tu_rs;
    bus.A_rtD     = rt;
    bus.Tuse_rt   = tu_rt;
    bus.AwriteD   = dst;
    bus.TnewD     = tnew;
    bus.RegWriteD = wr;
  endtask

  task automatic nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    rst_s    = 1'b1;
    nop();
    bus_s.A_rsD     = 5'd0;
    bus_s.Tuse_rs   = 2'd3;
    bus_s.A_rtD     = 5'd0;
    bus_s.Tuse_rt   = 2'd3;
    bus_s.AwriteD   = 5'd0;
    bus_s.TnewD     = 2'd0;
    bus_s.RegWriteD = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state and idle no-op stream
    for (int i = 0; i < 10; i++) begin
      expect_val("idle_stall", S_STALL, 0);
      expect_val("idle_flush", S_FLUSH, 0);
      expect_val("idle_fad",   S_FAD,   0);
      expect_val("idle_fbd",   S_FBD,   0);
      expect_val("idle_fae",   S_FAE,   0);
      expect_val("idle_fbe",   S_FBE,   0);
      expect_val("idle_cnt",   S_CNT,   0);
      drain();
      tick();
    end

    // lw $1 then add using $1 (Tuse 1)
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b1);
    expect_val("lwadd_c0_stall", S_STALL, 0);
    drain();
    tick();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd4, 2'd1, 1'b1);
    expect_val("lwadd_c1_stall", S_STALL, 1);
    expect_val("lwadd_c1_flush", S_FLUSH, 1);
    drain();
    tick();
    expect_val("lwadd_c2_stall", S_STALL, 0);
    expect_val("lwadd_c2_flush", S_FLUSH, 0);
    expect_val("lwadd_c2_fad",   S_FAD,   0);
    drain();
    tick();
    nop();
    expect_val("lwadd_c3_fae",   S_FAE,   2);
    expect_val("lwadd_c3_fbe",   S_FBE,   0);
    expect_val("lwadd_c3_stall", S_STALL, 0);
    expect_val("lwadd_cnt",      S_CNT,   1);
    drain();
    tick();

    // add $2 then beq on rs=$2 (Tuse 0)
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b1);
    expect_val("addbeq_c0_stall", S_STALL, 0);
    drain();
    tick();
    set_d(5'd2, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    expect_val("addbeq_c1_stall", S_STALL, 1);
    drain();
    tick();
    expect_val("addbeq_c2_stall", S_STALL, 0);
    expect_val("addbeq_c2_fad",   S_FAD,   1);
    expect_val("addbeq_cnt",      S_CNT,   1);
    drain();
    tick();

    // lw $3 then beq on rt=$3 (Tuse 0)
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2, 1'b1);
    expect_val("lwbeq_c0_stall", S_STALL, 0);
    drain();
    tick();
    set_d(5'd0, 2'd3, 5'd3, 2'd0, 5'd0, 2'd0, 1'b0);
    expect_val("lwbeq_c1_stall", S_STALL, 1);
    expect_val("lwbeq_c1_flush", S_FLUSH, 1);
    drain();
    tick();
    expect_val("lwbeq_c2_stall", S_STALL, 1);
    drain();
    tick();
    expect_val("lwbeq_c3_stall", S_STALL, 0);
    expect_val("lwbeq_c3_fbd",   S_FBD,   2);
    expect_val("lwbeq_c3_fad",   S_FAD,   0);
    expect_val("lwbeq_cnt",      S_CNT,   2);
    drain();
    tick();

    // $0 destination and non-writing destination never create dependencies
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1, 1'b1);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0);
    expect_val("zero_stall", S_STALL, 0);
    expect_val("zero_fad",   S_FAD,   0);
    expect_val("zero_fbd",   S_FBD,   0);
    drain();
    tick();
    set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0);
    expect_val("nowr_c1_stall", S_STALL, 0);
    expect_val("nowr_c1_fad",   S_FAD,   0);
    drain();
    tick();
    expect_val("nowr_c2_stall", S_STALL, 0);
    expect_val("nowr_c2_fad",   S_FAD,   0);
    expect_val("nowr_c2_fbd",   S_FBD,   0);
    drain();
    tick();
    expect_val("nowr_c3_fad", S_FAD, 0);
    expect_val("nowr_c3_fae", S_FAE, 0);
    expect_val("nowr_c3_fbe", S_FBE, 0);
    expect_val("nowr_cnt",    S_CNT, 0);
    drain();
    tick();

    // reset asserted during the first stall cycle of lw/beq
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2, 1'b1);
    tick();
    set_d(5'd0, 2'd3, 5'd3, 2'd0, 5'd0, 2'd0, 1'b0);
    expect_val("rstmid_pre_stall", S_STALL, 1);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_val("rstmid_stall", S_STALL, 0);
    expect_val("rstmid_cnt",   S_CNT,   0);
    drain();
    tick();
    expect_val("rstmid_after_stall", S_STALL, 0);
    expect_val("rstmid_after_cnt",   S_CNT,   0);
    drain();

    // self-dependent load stream on the 2-bit counter copy
    bus_s.A_rsD     = 5'd1;
    bus_s.Tuse_rs   = 2'd0;
    bus_s.AwriteD   = 5'd1;
    bus_s.TnewD     = 2'd2;
    bus_s.RegWriteD = 1'b1;
    tick();
    rst_s = 1'b0;
    expect_val("sat_start", S_CNTS, 0);
    drain();
    tick();
    tick();
    tick();
    expect_val("sat_mid", S_CNTS, 2);
    drain();
    for (int i = 0; i < 9; i++) tick();
    expect_val("sat_hold", S_CNTS, 3);
    drain();
    for (int i = 0; i < 6; i++) tick();
    expect_val("sat_hold2", S_CNTS, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall and forwarding controller for the five-stage pipeline. It takes the Tuse/Tnew and register-address information produced in Decode and keeps its own shadow copy of the E, M and W pipeline records. From these it generates the stall/flush controls for F/D/E and the bypass selects for the Decode comparator and the Execute ALU operands. It also counts stall cycles for performance measurement.

## Interface
Parameters:
- CNT_W, default 32: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all internal records and the counter.
- Tuse_rs  in  2  cycles until Decode's instruction needs rs; 3 = rs unused.
- Tuse_rt  in  2  same for rt.
- TnewD  in  2  cycles after entering E until the result exists at the E/M boundary (ALU 1, load 2, link 0).
- A_rsD  in  5  rs address of the instruction in D.
- A_rtD  in  5  rt address of the instruction in D.
- AwriteD  in  5  destination register of the instruction in D.
- RegWriteD  in  1  D instruction writes the GRF.
- stall  out  1  hold PC and the F/D register (their enables are the inverse of this).
- flushE  out  1  load a bubble into the D/E register; always equal to stall.
- fwdAD  out  2  rs source for Decode: 00 GRF, 01 ALUoutM, 10 W write-back data.
- fwdBD  out  2  rt source for Decode, same encoding.
- fwdAE  out  2  rs source for the Execute ALU, same encoding (00 = value latched in D/E).
- fwdBE  out  2  rt source for the Execute ALU, same encoding.
- stall_cnt  out  CNT_W  number of stall cycles since reset.

## Operation
- Each internal record holds {rs, rt, dst, Tnew, valid-write}. There is one record each for E, M and W.
- dst is stored as 0 whenever RegWrite is 0. Destination $0 never creates a dependency.
- Per clock when not stalled:
  - E ← D inputs, with Tnew = TnewD.
  - M ← E, with Tnew = max(TnewE−1, 0).
  - W ← M, with Tnew = 0.
- Per clock when stalled:
  - E ← bubble (all fields 0).
  - M and W advance as normal.
- stall is combinational and asserts when, for rs or rt with Tuse ≠ 3, either condition holds:
  - (A == dstE ≠ 0 and Tuse < TnewE), or
  - (A == dstM ≠ 0 and Tuse < TnewM).
- Decode forwarding (fwdAD/fwdBD):
  - 01 if A == dstM ≠ 0 and TnewM == 0;
  - else 10 if A == dstW ≠ 0;
  - else 00.
  - M has priority over W.
- Execute forwarding (fwdAE/fwdBE) uses the same rule, applied to rsE/rtE against the M and W records.
- E-stage forwarding is never needed for D: any E match with TnewE > 0 and Tuse == 0 stalls; TnewE == 0 cannot be used from E.
- stall_cnt increments by 1 on every clock with stall = 1. It saturates at all-ones and does not wrap.

## Timing
- Reset values: all records 0, stall = 0, flushE = 0, all fwd* = 00, stall_cnt = 0.
- stall and the fwd* outputs are combinational from the current records and the D inputs, valid in the same cycle. There are no registered outputs apart from stall_cnt.
- stall_cnt reflects the stall of the previous cycle (1-cycle latency).
- Dependency latencies:
  - Load followed by an ALU user (Tuse 1): exactly 1 stall cycle.
  - Load followed by a branch (Tuse 0): 2 stall cycles.
  - ALU result followed by a branch: 1 stall cycle.
- Reset asserted mid-stall: the next edge clears all records, so stall deasserts in the following cycle. Reset dominates the counter increment.
- A source with Tuse = 3 never stalls. It may still report a forward select; that value is harmless.
- When both the M and W records match the same address, M is selected.

## Test plan
- Reset then no-op stream (all addresses 0) → stall = 0, all fwd = 00, stall_cnt = 0 for 10 cycles.
- lw $1 (TnewD = 2, dst 1), then add with rs = $1 (Tuse 1):
  - cycle 1: stall = 1, flushE = 1;
  - cycle 2: stall = 0;
  - cycle 3: with add in E, fwdAE = 10;
  - stall_cnt = 1.
- add $2 (TnewD 1), then beq rs = $2 (Tuse 0): 1 stall cycle, then fwdAD = 01 with add in M.
- lw $3, then beq rt = $3: stall for 2 consecutive cycles, then fwdBD = 10; stall_cnt = 2.
- Writer to $0 followed by a reader of $0, plus a writer with RegWriteD = 0 to $5 followed by a reader of $5 → no stall, fwd = 00.
- Assert reset during the first stall cycle of the lw/beq pair → stall = 0 next cycle, stall_cnt = 0; saturation check with CNT_W = 2 under continuous stall holds at 3.
